// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PC requests to instruction memory under a credit
// scheme, buffers in-order responses and hands {pc, instr} pairs to decode.
module fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instr,
  input  logic              id_ready,
  output logic              resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [ADDR_W-1:0] pc_d    [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [DATA_W-1:0] instr_d [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PW-1:0]     alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     used_q, used_d;
  logic [CW-1:0]     pend_q, pend_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              resp_err_q, resp_err_d;
  logic              credit_s, grant_s, pop_s, fill_s;

  // Credit counts responses still owed to flushed fetches, so they can never overrun the queue.
  assign credit_s  = ({1'b0, used_q} + {1'b0, drop_cnt_q}) < DEPTH_C;
  assign imem_req  = pc_valid & credit_s & ~flush;
  assign imem_addr = pc_in;
  assign grant_s   = imem_req & imem_gnt;
  assign pc_ready  = grant_s;
  assign id_valid  = filled_q[rd_ptr_q] & ~flush;
  assign pop_s     = id_valid & id_ready;
  assign id_pc     = pc_q[rd_ptr_q];
  assign id_instr  = instr_q[rd_ptr_q];
  assign resp_err  = resp_err_q;

  // Next-state: flush, response routing, pop, allocation and fill.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    used_d      = used_q;
    pend_d      = pend_q;
    drop_cnt_d  = drop_cnt_q;
    resp_err_d  = resp_err_q;
    fill_s      = 1'b0;
    if (flush) begin
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      used_d      = '0;
      pend_d      = '0;
      if (imem_rvalid) begin
        if ((drop_cnt_q == '0) && (pend_q == '0)) begin
          resp_err_d = 1'b1;
        end else begin
          drop_cnt_d = drop_cnt_q + pend_q - CW'(1);
        end
      end else begin
        drop_cnt_d = drop_cnt_q + pend_q;
      end
    end else begin
      if (imem_rvalid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else if (pend_q != '0) begin
          fill_s = 1'b1;
        end else begin
          resp_err_d = 1'b1;
        end
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (pop_s) begin
        filled_d[rd_ptr_q] = 1'b0;
        pc_d[rd_ptr_q]     = '0;
        instr_d[rd_ptr_q]  = '0;
        rd_ptr_d           = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (grant_s) begin
        pc_d[alloc_ptr_q]     = pc_in;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + PW'(1);
      end else begin
        alloc_ptr_d = alloc_ptr_q;
      end
      if (fill_s) begin
        instr_d[fill_ptr_q]  = imem_rdata;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PW'(1);
      end else begin
        fill_ptr_d = fill_ptr_q;
      end
      used_d = used_q + CW'(grant_s) - CW'(pop_s);
      pend_d = pend_q + CW'(grant_s) - CW'(fill_s);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      pend_q      <= '0;
      drop_cnt_q  <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      used_q      <= used_d;
      pend_q      <= pend_d;
      drop_cnt_q  <= drop_cnt_d;
      resp_err_q  <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven bench for fetch_queue (DEPTH=2) with an in-order memory model and
// a {pc, instr} scoreboard for decode-side outputs.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_ready;
  logic        resp_err;

  fetch_queue #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcv;
    logic [31:0] pc;
    logic        gnt;
    logic        rdy;
    logic        fl;
    logic        spur;
    int          lat;
    logic        e_req;
    logic        e_vld;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } mem_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t vt[$];
  mem_t mem_q[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input int pcv, input int pc, input int gnt, input int rdy,
                              input int fl, input int spur, input int lat,
                              input int er, input int ev, input int ee);
    vec_t v;
    v.pcv = (pcv != 0); v.pc = 32'(pc); v.gnt = (gnt != 0); v.rdy = (rdy != 0);
    v.fl = (fl != 0); v.spur = (spur != 0); v.lat = lat;
    v.e_req = (er != 0); v.e_vld = (ev != 0); v.e_err = (ee != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, check at the falling edge, then advance the models.
  task automatic apply(input vec_t v);
    pc_valid = v.pcv; pc_in = v.pc; imem_gnt = v.gnt; id_ready = v.rdy; flush = v.fl;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    if (mem_q.size() > 0 && (cyc - mem_q[0].cyc) >= v.lat) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(mem_q[0].pc);
      void'(mem_q.pop_front());
    end else if (v.spur) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_DEAD;
    end
    @(negedge clk);
    chk("imem_req", 32'(imem_req), 32'(v.e_req));
    chk("pc_ready", 32'(pc_ready), 32'(v.e_req & v.gnt));
    chk("imem_addr", imem_addr, v.pc);
    chk("id_valid", 32'(id_valid), 32'(v.e_vld));
    chk("resp_err", 32'(resp_err), 32'(v.e_err));
    if (id_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL sb_empty (cycle %0d): got id_pc %h, expected no valid entry", cyc, id_pc);
      end else begin
        chk("id_pc", id_pc, exp_q[0].pc);
        chk("id_instr", id_instr, exp_q[0].instr);
      end
    end
    if (v.fl) exp_q.delete();
    if (v.e_vld && v.rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (v.e_req && v.gnt) begin
      exp_q.push_back('{v.pc, data_of(v.pc)});
      mem_q.push_back('{v.pc, cyc});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // mk(pcv, pc, gnt, rdy, flush, spur, lat | exp req, exp id_valid, exp resp_err)
    // back-to-back fetch, one-cycle memory
    vt.push_back(mk(1, 0, 1, 1, 0, 0, 1, 1, 0, 0));
    vt.push_back(mk(1, 1, 1, 1, 0, 0, 1, 1, 0, 0));
    vt.push_back(mk(1, 2, 1, 1, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(1, 2, 1, 1, 0, 0, 1, 1, 1, 0));
    vt.push_back(mk(1, 3, 1, 1, 0, 0, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    // decode backpressure, then release
    vt.push_back(mk(1, 10, 1, 0, 0, 0, 1, 1, 0, 0));
    vt.push_back(mk(1, 11, 1, 0, 0, 0, 1, 1, 0, 0));
    vt.push_back(mk(1, 12, 1, 0, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(1, 12, 1, 0, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(1, 12, 1, 1, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(1, 12, 1, 1, 0, 0, 1, 1, 1, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    // flush with two outstanding, three-cycle memory
    vt.push_back(mk(1, 4, 1, 1, 0, 0, 3, 1, 0, 0));
    vt.push_back(mk(1, 5, 1, 1, 0, 0, 3, 1, 0, 0));
    vt.push_back(mk(1, 8, 1, 1, 1, 0, 3, 0, 0, 0));
    vt.push_back(mk(1, 8, 1, 1, 0, 0, 3, 0, 0, 0));
    vt.push_back(mk(1, 8, 1, 1, 0, 0, 3, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 3, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 3, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 3, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 3, 0, 1, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 3, 0, 0, 0));
    // flush coincident with the first response, two-cycle memory
    vt.push_back(mk(1, 4, 1, 1, 0, 0, 2, 1, 0, 0));
    vt.push_back(mk(1, 5, 1, 1, 0, 0, 2, 1, 0, 0));
    vt.push_back(mk(1, 8, 1, 1, 1, 0, 2, 0, 0, 0));
    vt.push_back(mk(1, 8, 1, 1, 0, 0, 2, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 2, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 2, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 2, 0, 1, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 2, 0, 0, 0));
    // flush while the head is filled: id_valid masked, nothing popped
    vt.push_back(mk(1, 6, 1, 0, 0, 0, 1, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    // spurious response, then a normal fetch with the flag held
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0));
    vt.push_back(mk(1, 20, 1, 1, 0, 0, 1, 1, 0, 1));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1));
    // two filled entries held under backpressure before the async reset
    vt.push_back(mk(1, 30, 1, 0, 0, 0, 1, 1, 0, 1));
    vt.push_back(mk(1, 31, 1, 0, 0, 0, 1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1));

    reset = 1'b1; pc_valid = 1'b0; pc_in = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = 32'h0; flush = 1'b0; id_ready = 1'b0;
    #12;
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_pc_ready", 32'(pc_ready), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) apply(vt[i]);

    // asynchronous reset between edges with two entries filled and resp_err set
    pc_valid = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_id_valid", 32'(id_valid), 32'h0);
    chk("async_resp_err", 32'(resp_err), 32'h0);
    chk("async_drop_cnt", 32'(dut.drop_cnt_q), 32'h0);
    chk("async_id_pc", id_pc, 32'h0);
    chk("async_imem_req", 32'(imem_req), 32'h0);
    #2;
    reset = 1'b0;
    mem_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    apply(mk(1, 40, 1, 1, 0, 0, 1, 1, 0, 0));
    apply(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    apply(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 0));
    apply(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
